// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath: GF(2^8) helpers and
// the FSM state type used by the iterative column-mixing stages.
package aes_pkg;

    localparam logic [7:0] AES_RED = 8'h1b;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_RED : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcol_if.sv
// Block-level bus for inv_mixcol: state in with valid/flags, result out with
// done pulse, and the ready back-pressure signal.
interface inv_mixcol_if;

    logic [128:1] plain_row;
    logic         ok_row;
    logic         is_first;
    logic         is_final;
    logic         ready;
    logic [128:1] plain_col;
    logic         ok_col;

    modport master (
        output plain_row, ok_row, is_first, is_final,
        input  ready, plain_col, ok_col
    );

    modport slave (
        input  plain_row, ok_row, is_first, is_final,
        output ready, plain_col, ok_col
    );

endinterface

// File: rtl/inv_mixcol_column.sv
// Combinational InvMixColumns for one 32-bit column; row 0 is the top byte.
// Coefficient multiples are assembled from a single xtime chain per byte.
module inv_mixcol_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];

    genvar g;
    for (g = 0; g < 4; g++) begin : g_byte
        assign w_a[g]  = i_col[31-8*g -: 8];
        assign w_x2[g] = xtime(w_a[g]);
        assign w_x4[g] = xtime(w_x2[g]);
        assign w_x8[g] = xtime(w_x4[g]);
        assign w_m9[g] = w_x8[g] ^ w_a[g];
        assign w_mb[g] = w_x8[g] ^ w_x2[g] ^ w_a[g];
        assign w_md[g] = w_x8[g] ^ w_x4[g] ^ w_a[g];
        assign w_me[g] = w_x8[g] ^ w_x4[g] ^ w_x2[g];
    end

    // Row r sees {0e,0b,0d,09} starting at its own byte and wrapping around.
    for (g = 0; g < 4; g++) begin : g_out
        assign o_col[31-8*g -: 8] = w_me[g] ^ w_mb[(g+1)%4] ^ w_md[(g+2)%4] ^ w_m9[(g+3)%4];
    end

endmodule

// File: rtl/inv_mixcol.sv
// Iterative InvMixColumns: one column per clock through a shared column unit,
// with a single-cycle bypass for the first/final inverse-cipher rounds.
module inv_mixcol
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inv_mixcol_if.slave  bus
);

    state_t       r_state;
    state_t       w_stateNext;
    logic [128:1] r_stateReg;
    logic [1:0]   r_colIdx;
    logic [128:1] r_plainCol;
    logic         r_okCol;

    logic         w_ready;
    logic         w_accept;
    logic         w_bypass;
    logic [31:0]  w_colIn;
    logic [31:0]  w_colOut;

    assign w_ready  = (r_state == IDLE);
    assign w_accept = bus.ok_row && w_ready;
    assign w_bypass = bus.is_first | bus.is_final;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_bypass) w_stateNext = RUN;
            RUN:     if (r_colIdx == 2'd3)      w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_colIn = r_stateReg[128:97];
        case (r_colIdx)
            2'd0: w_colIn = r_stateReg[128:97];
            2'd1: w_colIn = r_stateReg[96:65];
            2'd2: w_colIn = r_stateReg[64:33];
            2'd3: w_colIn = r_stateReg[32:1];
            default: w_colIn = r_stateReg[128:97];
        endcase
    end

    inv_mixcol_column u_column (
        .i_col (w_colIn),
        .o_col (w_colOut)
    );

    // Result columns land in place, so plain_col is only meaningful with ok_col.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stateReg <= '0;
            r_colIdx   <= 2'd0;
            r_plainCol <= '0;
            r_okCol    <= 1'b0;
        end else begin
            r_okCol <= 1'b0;
            if (w_accept) begin
                r_stateReg <= bus.plain_row;
                r_colIdx   <= 2'd0;
                if (w_bypass) begin
                    r_plainCol <= bus.plain_row;
                    r_okCol    <= 1'b1;
                end
            end else if (r_state == RUN) begin
                case (r_colIdx)
                    2'd0: r_plainCol[128:97] <= w_colOut;
                    2'd1: r_plainCol[96:65]  <= w_colOut;
                    2'd2: r_plainCol[64:33]  <= w_colOut;
                    2'd3: r_plainCol[32:1]   <= w_colOut;
                    default: r_plainCol[128:97] <= w_colOut;
                endcase
                r_colIdx <= r_colIdx + 2'd1;
                if (r_colIdx == 2'd3) r_okCol <= 1'b1;
            end
        end
    end

    assign bus.ready     = w_ready;
    assign bus.plain_col = r_plainCol;
    assign bus.ok_col    = r_okCol;

endmodule

// File: tb/tb_inv_mixcol.sv
// Directed and random checks for inv_mixcol: known-answer vectors, bypass
// modes, busy drop, back-to-back accept, mid-run reset and MixColumns round trip.
module tb_inv_mixcol;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    inv_mixcol_if bus ();

    inv_mixcol dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic         isFirst;
        logic         isFinal;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    // Reference forward MixColumns, used to undo the DUT result.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] fwdMix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
            r[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one accept at a negedge; returns at the following negedge with ok_row low.
    task automatic applyStimulus(input logic [127:0] din, input logic f, input logic fin);
        bus.plain_row = din;
        bus.is_first  = f;
        bus.is_final  = fin;
        bus.ok_row    = 1'b1;
        @(negedge clk);
        bus.ok_row    = 1'b0;
        bus.is_first  = 1'b0;
        bus.is_final  = 1'b0;
    endtask

    task automatic waitDone(output logic [127:0] res, output int lat);
        lat = 1;
        while (!bus.ok_col && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        res = bus.plain_col;
    endtask

    logic [127:0] res;
    logic [127:0] stA, stB, expA, expB;
    int           lat;
    int           pulses;

    initial begin
        assertCount = 0;
        failCount   = 0;
        bus.plain_row = '0;
        bus.ok_row    = 1'b0;
        bus.is_first  = 1'b0;
        bus.is_final  = 1'b0;

        stA  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        expA = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        stB  = 128'h9fdc589d_8e4da1bc_01010101_d5d5d7d6;
        expB = 128'hf20a225c_db135345_01010101_d4d4d4d5;

        vecs[0] = '{stA, 1'b0, 1'b0, expA, 5};
        vecs[1] = '{stA, 1'b0, 1'b1, stA, 1};
        vecs[2] = '{stA, 1'b1, 1'b0, stA, 1};
        vecs[3] = '{stA, 1'b1, 1'b1, stA, 1};
        vecs[4] = '{stB, 1'b0, 1'b0, expB, 5};
        vecs[5] = '{128'h0, 1'b0, 1'b0, 128'h0, 5};
        vecs[6] = '{128'hc6c6c6c6_01000000_00010000_4d7ebdf8, 1'b0, 1'b0,
                    128'hc6c6c6c6_0e090d0b_0b0e090d_2d26314c, 5};
        vecs[7] = '{128'h01000000_01000000_01000000_01000000, 1'b0, 1'b0,
                    128'h0e090d0b_0e090d0b_0e090d0b_0e090d0b, 5};
        vecs[8] = '{128'h4d7ebdf8_4d7ebdf8_00000000_c6c6c6c6, 1'b0, 1'b0,
                    128'h2d26314c_2d26314c_00000000_c6c6c6c6, 5};
        vecs[9] = '{128'hdeadbeef_01234567_89abcdef_fedcba98, 1'b1, 1'b1,
                    128'hdeadbeef_01234567_89abcdef_fedcba98, 1};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset plain_col", bus.plain_col, 128'h0);
        checkOutput("reset ok_col", {127'h0, bus.ok_col}, 128'h0);
        checkOutput("reset ready", {127'h0, bus.ready}, 128'h1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("vec%0d ready", i), {127'h0, bus.ready}, 128'h1);
            applyStimulus(vecs[i].din, vecs[i].isFirst, vecs[i].isFinal);
            waitDone(res, lat);
            checkOutput($sformatf("vec%0d result", i), res, vecs[i].dout);
            checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
            @(negedge clk);
            checkOutput($sformatf("vec%0d pulse width", i), {127'h0, bus.ok_col}, 128'h0);
        end

        // A second valid during RUN must be dropped without a second pulse.
        applyStimulus(stA, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("busy ready low", {127'h0, bus.ready}, 128'h0);
        bus.plain_row = stB;
        bus.ok_row    = 1'b1;
        @(negedge clk);
        bus.ok_row    = 1'b0;
        pulses = 0;
        res    = '0;
        for (int k = 0; k < 10; k++) begin
            if (bus.ok_col) begin
                pulses++;
                res = bus.plain_col;
            end
            @(negedge clk);
        end
        checkOutput("busy pulse count", 128'(pulses), 128'd1);
        checkOutput("busy result", res, expA);

        // Next accept coincides with the done pulse of the previous block.
        applyStimulus(stA, 1'b0, 1'b0);
        waitDone(res, lat);
        checkOutput("b2b first result", res, expA);
        checkOutput("b2b ready on done", {127'h0, bus.ready}, 128'h1);
        applyStimulus(stB, 1'b0, 1'b0);
        waitDone(res, lat);
        checkOutput("b2b second result", res, expB);
        checkOutput("b2b second latency", 128'(lat), 128'd5);
        @(negedge clk);

        // Reset while col_idx is 2 abandons the block.
        applyStimulus(stA, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst plain_col", bus.plain_col, 128'h0);
        checkOutput("midrst ok_col", {127'h0, bus.ok_col}, 128'h0);
        checkOutput("midrst ready", {127'h0, bus.ready}, 128'h1);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ok_col) pulses++;
        end
        checkOutput("midrst no pulse", 128'(pulses), 128'd0);
        applyStimulus(stB, 1'b0, 1'b0);
        waitDone(res, lat);
        checkOutput("midrst next result", res, expB);
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            stA = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(stA, 1'b0, 1'b0);
            waitDone(res, lat);
            checkOutput($sformatf("rand%0d roundtrip", n), fwdMix(res), stA);
            if (lat != 5) checkOutput($sformatf("rand%0d latency", n), 128'(lat), 128'd5);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/inv_mixcol.md
# inv_mixcol

Iterative AES InvMixColumns stage for the decryption datapath, the inverse counterpart of the forward column-mixing stage used in encryption. It accepts one 128-bit state with a valid pulse and multiplies each 32-bit column by the inverse MDS matrix {0e,0b,0d,09}, one column per clock through a shared column unit. It returns the result with a one-cycle done pulse. Rounds flagged as first or final bypass the transform, matching the inverse-cipher round schedule.

## Interface
- No parameters. Width is fixed at 128 bits (4 columns × 4 bytes).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- plain_row  in  128  input state. Bit range is [128:1]. Column c occupies [128-32c : 97-32c]. Row 0 is the highest byte of each column.
- ok_row  in  1  input valid. Sampled only when ready is high.
- is_first  in  1  bypass flag. Sampled with ok_row.
- is_final  in  1  bypass flag. Sampled with ok_row.
- ready  out  1  high when idle and able to accept (state == IDLE).
- plain_col  out  128  result state. Same bit layout as plain_row.
- ok_col  out  1  one-cycle done pulse.

## Operation
- FSM states are IDLE and RUN. A 2-bit column counter col_idx runs 0..3.
- **Accept:** on an edge where ok_row && ready:
  - capture plain_row into state_reg;
  - capture bypass = is_first | is_final;
  - clear col_idx.
- **Bypass accept:**
  - plain_col <= plain_row;
  - ok_col <= 1;
  - stay in IDLE.
- **Normal accept:** go to RUN.
- **RUN, each edge:**
  - column col_idx of state_reg goes through the column unit;
  - the result is written into the same column slot of plain_col;
  - col_idx increments.
- **Leaving RUN:** on the col_idx == 3 edge, set ok_col <= 1 and return to IDLE.
- **Column transform** (GF(2^8), polynomial 0x11b), output b from input a:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3;
  - each later row is a cyclic rotation of the coefficients.
- **Multiplier construction:**
  - build multiples from xtime chains: x2, x4, x8;
  - 09 = x8^x1;
  - 0b = x8^x2^x1;
  - 0d = x8^x4^x1;
  - 0e = x8^x4^x2.
- **plain_col holding rules:**
  - holds its value between results;
  - partially updated columns are visible during RUN;
  - consumers use plain_col only while ok_col is high.
- **ok_row while busy:** ignored and not queued. Upstream must honour ready.
- **Both flags high:** bypass, same as either flag alone.

## Timing
- **Reset values:**
  - plain_col = 0, ok_col = 0;
  - FSM = IDLE, so ready = 1;
  - col_idx = 0.
- **Reset mid-RUN:**
  - the block is abandoned;
  - no ok_col pulse;
  - outputs return to reset values on the next edge.
- **Transform latency:** accept edge E0, columns written on E1..E4, ok_col high in the cycle after E4.
- **Bypass latency:** ok_col high in the cycle after E0.
- **ok_col width:** exactly one cycle per accepted block.
- **Ready timing:**
  - ready is combinational from state and low throughout RUN;
  - ready is high in the same cycle ok_col is high, so the next accept can coincide with the done pulse.
- **Throughput:** one transformed block per 5 cycles; one bypass block per cycle.

## Structure
- Shared package aes_pkg holds:
  - function xtime(byte) (shift, conditional ^8'h1b);
  - constant AES_RED = 8'h1b;
  - FSM state typedef.
- One sub-module, inv_mixcol_column: 32-bit combinational column transform, instantiated once and time-multiplexed.
- The column select mux and write-back are in the top level.

## Test plan
- **Transform vector:**
  - stimulus: plain_row = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, ok_row=1, flags 0;
  - response: ok_col 5 cycles after the accept edge, plain_col = db135345_f20a225c_01010101_d4d4d4d5.
- **Bypass:**
  - stimulus: the same input with is_final=1;
  - response: ok_col the next cycle, plain_col equal to the input.
  - Repeat with is_first=1 and with both flags set.
- **Busy drop:**
  - stimulus: a second ok_row while in RUN with a different state;
  - response: ignored, first result correct, exactly one ok_col pulse.
- **Back-to-back:**
  - stimulus: a new ok_row in the ok_col cycle;
  - response: accepted; second result after 5 more cycles.
- **Reset mid-RUN:**
  - stimulus: rst=1 at col_idx=2;
  - response: no ok_col, plain_col=0, ready=1; the next block computes correctly.
- **Random:**
  - 1000 random states;
  - each result passed through a reference MixColumns model returns the original input.
